fifo2pcie_tx: RTL and testbench
===============================

// Module: fifo2pcie_tx
// PURPOSE
// - Transmit-side counterpart of the RX snoop path. Pops TLP beats from the Eth->PCIe
//   FIFO (first-word-fall-through, filled by the NetTLP decapsulator) and drives the
//   64-bit PCIe TX AXI-stream of the 7-series PCIe core.
// - Gates packet start on core buffer credit. Checks beat count against FIFO tlp_len.
// - Cleanly aborts (src_dsc) truncated/stalled TLPs; discards malformed entries.
// PARAMETERS
// - TIMEOUT_VAL   500  max consecutive empty-FIFO cycles tolerated inside a packet
// - MIN_BUF_AV    2    minimum tx_buf_av to start a TLP
// PORTS
// - pcie_clk      in   1   PCIe user clock; the only clock
// - pcie_rst_n    in   1   asynchronous active-low reset
// - fifo_empty    in   1   FIFO empty
// - fifo_tdata    in   64  FIFO head beat data
// - fifo_tkeep    in   8   FIFO head byte enables
// - fifo_tlast    in   1   FIFO head last beat
// - fifo_tlp_len  in   11  TLP byte length incl. header; meaningful on first beat only
// - rd_en         out  1   pop FIFO head
// - tx_buf_av     in   6   core TX buffer availability
// - tx_tready     in   1   core ready
// - tx_tvalid     out  1   beat valid
// - tx_tlast      out  1   last beat
// - tx_tkeep      out  8   byte enables
// - tx_tdata      out  64  beat data
// - tx_tuser      out  4   [3]=src_dsc, [2:0]=0
// BEHAVIOUR
// - Reset (async assert, sync deassert at pcie_clk): state=IDLE, counters 0.
//   Reset outputs: rd_en=0, tx_tvalid=0, tx_tlast=0, tx_tkeep=0, tx_tdata=0, tx_tuser=0.
// - Datapath is combinational FIFO->TX; zero-cycle latency.
// - Pop rule: rd_en = tx_tvalid & tx_tready in SEND states; = !fifo_empty in DRAIN.
// - tx_tvalid never deasserts mid-beat once raised until accepted (AXI rule).
// - Expected beats: exp = (tlp_len + 7) >> 3, latched on first beat; beat_cnt counts
//   accepted beats.
// - IDLE: wait for !fifo_empty & tx_buf_av >= MIN_BUF_AV.
//   - tlp_len < 12: go to DRAIN, no tvalid.
//   - first beat with fifo_tlast=1: go to DRAIN, no tvalid.
//   - otherwise: assert tvalid on beat 0; on accept go to DATA.
// - DATA: tvalid = !fifo_empty.
//   - Accepted beat with fifo_tlast & beat_cnt+1 == exp: go to IDLE (normal end).
//   - fifo_tlast with beat_cnt+1 < exp: forward with tuser[3]=1; go to IDLE.
//   - beat_cnt+1 == exp & !fifo_tlast: force tx_tlast=1, tuser[3]=1; go to DRAIN.
//   - fifo_empty for TIMEOUT_VAL consecutive cycles: go to ABORT.
// - ABORT: synthetic beat tdata=0, tkeep=8'hFF, tlast=1, tuser[3]=1, no pop.
//   On tready go to DRAIN.
// - DRAIN: pop until a beat with fifo_tlast is popped, then go to IDLE.
//   No tvalid in DRAIN.
// - Timeout counter: 10 bits, clears on any pop and in IDLE; saturates at TIMEOUT_VAL.
// - tx_buf_av is sampled only at packet start; a drop mid-packet does not stall.
// - Reset mid-packet: TX outputs drop at once; partial TLP left in FIFO is the
//   FIFO owner's concern.
// CONFIGURATION
// - FIFO2PCIE_TX_STATS_EN defined:
//   - adds outputs stat_pkt [31:0] (normal ends), stat_abort [31:0]
//     (src_dsc beats sent), and stat_drop [31:0] (DRAIN entries from IDLE).
//   - All counters wrap modulo 2^32 and reset to 0.
// - FIFO2PCIE_TX_STATS_EN undefined: ports and counters absent; behaviour otherwise
//   identical.
// TESTING
// - 3DW MWr, tlp_len=16, 2 beats, tready=1 -> 2 TX beats, tlast on beat 2,
//   tuser=0, 2 rd_en pulses.
// - Same TLP, tready toggled 1010 -> data stable while tvalid&!tready; completes after
//   accepts; no duplicated/lost beats.
// - tlp_len=24 (exp=3), FIFO tlast on beat 2 -> beat 2 sent with tlast=1, tuser[3]=1;
//   next TLP starts clean.
// - tlp_len=16, FIFO packet 4 beats -> beat 2 sent with tlast=1, tuser[3]=1;
//   beats 3-4 popped silently.
// - FIFO empty after beat 1 for 500 cycles -> synthetic beat tkeep=FF, tlast=1,
//   tuser[3]=1; late beats drained.
// - tx_buf_av=1 with data queued -> no tvalid; raise to 2 -> TLP starts next cycle.
// - pcie_rst_n pulled low mid-DATA -> outputs 0 immediately; after release, IDLE.

Source files
------------

// File: rtl/fifo2pcie_tx.sv
// fifo2pcie_tx: pops TLP beats from the first-word-fall-through Eth->PCIe FIFO and
// drives the 64-bit PCIe TX AXI-stream. A packet starts only when the core reports
// enough buffer credit. The beat count is checked against tlp_len. Truncated or stalled
// TLPs are ended with src_dsc, and malformed entries are drained.
// Optional build macro FIFO2PCIE_TX_STATS_EN adds the stat_pkt/stat_abort/stat_drop counters.
module fifo2pcie_tx #(
    parameter int unsigned TIMEOUT_VAL = 500,
    parameter int unsigned MIN_BUF_AV  = 2
) (
    input  logic        pcie_clk,
    input  logic        pcie_rst_n,
    input  logic        fifo_empty,
    input  logic [63:0] fifo_tdata,
    input  logic [7:0]  fifo_tkeep,
    input  logic        fifo_tlast,
    input  logic [10:0] fifo_tlp_len,
    output logic        rd_en,
    input  logic [5:0]  tx_buf_av,
    input  logic        tx_tready,
    output logic        tx_tvalid,
    output logic        tx_tlast,
    output logic [7:0]  tx_tkeep,
    output logic [63:0] tx_tdata,
    output logic [3:0]  tx_tuser
`ifdef FIFO2PCIE_TX_STATS_EN
    ,
    output logic [31:0] stat_pkt,
    output logic [31:0] stat_abort,
    output logic [31:0] stat_drop
`endif
);

    localparam int unsigned CNT_W   = 9;
    localparam int unsigned TO_W    = 10;
    localparam int unsigned MIN_LEN = 12;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DATA  = 2'd1;
    localparam logic [1:0] S_ABORT = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic [CNT_W-1:0] exp_q, exp_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             pend_q, pend_d;
    logic             run_q, run_d;

    logic [CNT_W-1:0] exp_calc;
    logic [CNT_W-1:0] cnt_inc;
    logic             cnt_end;
    logic             start_ok;

    // State and counter registers; run_q gives a synchronous release after the async reset
    always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
        if (!pcie_rst_n) begin
            state_q    <= S_IDLE;
            beat_cnt_q <= '0;
            exp_q      <= '0;
            to_cnt_q   <= '0;
            pend_q     <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            exp_q      <= exp_d;
            to_cnt_q   <= to_cnt_d;
            pend_q     <= pend_d;
            run_q      <= run_d;
        end
    end

    // Next-state logic and the zero-latency FIFO->TX datapath
    always_comb begin
        state_d    = state_q;
        beat_cnt_d = beat_cnt_q;
        exp_d      = exp_q;
        to_cnt_d   = to_cnt_q;
        pend_d     = pend_q;
        run_d      = 1'b1;
        rd_en      = 1'b0;
        tx_tvalid  = 1'b0;
        tx_tlast   = 1'b0;
        tx_tkeep   = 8'h00;
        tx_tdata   = 64'h0;
        tx_tuser   = 4'h0;

        exp_calc = CNT_W'((12'(fifo_tlp_len) + 12'd7) >> 3);
        cnt_inc  = CNT_W'(beat_cnt_q + 1'b1);
        cnt_end  = (cnt_inc == exp_q);
        // A beat already offered keeps its credit even if tx_buf_av drops while stalled
        start_ok = run_q && !fifo_empty && (pend_q || (tx_buf_av >= 6'(MIN_BUF_AV)));

        case (state_q)
            S_IDLE: begin
                to_cnt_d = '0;
                if (start_ok) begin
                    if ((fifo_tlp_len < 11'(MIN_LEN)) || fifo_tlast) begin
                        state_d = S_DRAIN;
                    end else begin
                        tx_tvalid = 1'b1;
                        tx_tdata  = fifo_tdata;
                        tx_tkeep  = fifo_tkeep;
                        if (tx_tready) begin
                            rd_en      = 1'b1;
                            beat_cnt_d = CNT_W'(1);
                            exp_d      = exp_calc;
                            pend_d     = 1'b0;
                            state_d    = S_DATA;
                        end else begin
                            pend_d = 1'b1;
                        end
                    end
                end
            end
            S_DATA: begin
                if (!fifo_empty) begin
                    to_cnt_d  = '0;
                    tx_tvalid = 1'b1;
                    tx_tdata  = fifo_tdata;
                    tx_tkeep  = fifo_tkeep;
                    // Early FIFO end or count reached without FIFO end both flag src_dsc
                    tx_tlast    = fifo_tlast | cnt_end;
                    tx_tuser[3] = fifo_tlast ^ cnt_end;
                    if (tx_tready) begin
                        rd_en      = 1'b1;
                        beat_cnt_d = cnt_inc;
                        if (fifo_tlast) begin
                            state_d = S_IDLE;
                        end else if (cnt_end) begin
                            state_d = S_DRAIN;
                        end
                    end
                end else begin
                    to_cnt_d = (to_cnt_q >= TO_W'(TIMEOUT_VAL)) ? to_cnt_q
                                                                : TO_W'(to_cnt_q + 1'b1);
                    if (to_cnt_d == TO_W'(TIMEOUT_VAL)) begin
                        state_d = S_ABORT;
                    end
                end
            end
            S_ABORT: begin
                to_cnt_d    = '0;
                tx_tvalid   = 1'b1;
                tx_tkeep    = 8'hFF;
                tx_tlast    = 1'b1;
                tx_tuser[3] = 1'b1;
                if (tx_tready) begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                to_cnt_d = '0;
                rd_en    = !fifo_empty;
                if (!fifo_empty && fifo_tlast) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

`ifdef FIFO2PCIE_TX_STATS_EN
    logic [31:0] stat_pkt_q, stat_pkt_d;
    logic [31:0] stat_abort_q, stat_abort_d;
    logic [31:0] stat_drop_q, stat_drop_d;

    // Statistics event decode: normal ends, src_dsc beats, malformed drops
    always_comb begin
        stat_pkt_d   = stat_pkt_q;
        stat_abort_d = stat_abort_q;
        stat_drop_d  = stat_drop_q;
        if ((state_q == S_DATA) && tx_tvalid && tx_tready && fifo_tlast && cnt_end) begin
            stat_pkt_d = stat_pkt_q + 32'd1;
        end
        if (tx_tvalid && tx_tready && tx_tuser[3]) begin
            stat_abort_d = stat_abort_q + 32'd1;
        end
        if ((state_q == S_IDLE) && (state_d == S_DRAIN)) begin
            stat_drop_d = stat_drop_q + 32'd1;
        end
    end

    // Statistics counters, wrapping modulo 2^32
    always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
        if (!pcie_rst_n) begin
            stat_pkt_q   <= '0;
            stat_abort_q <= '0;
            stat_drop_q  <= '0;
        end else begin
            stat_pkt_q   <= stat_pkt_d;
            stat_abort_q <= stat_abort_d;
            stat_drop_q  <= stat_drop_d;
        end
    end

    assign stat_pkt   = stat_pkt_q;
    assign stat_abort = stat_abort_q;
    assign stat_drop  = stat_drop_q;
`endif

endmodule

// File: tb/tb_fifo2pcie_tx.sv
// tb_fifo2pcie_tx: scoreboard bench for fifo2pcie_tx with a queue-modelled FWFT FIFO.
module tb_fifo2pcie_tx;

    localparam int TO = 500;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [10:0] len;
    } fent_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [3:0]  user;
    } txb_t;

    logic        pcie_clk = 1'b0;
    logic        pcie_rst_n;
    logic        fifo_empty;
    logic [63:0] fifo_tdata;
    logic [7:0]  fifo_tkeep;
    logic        fifo_tlast;
    logic [10:0] fifo_tlp_len;
    logic        rd_en;
    logic [5:0]  tx_buf_av;
    logic        tx_tready;
    logic        tx_tvalid;
    logic        tx_tlast;
    logic [7:0]  tx_tkeep;
    logic [63:0] tx_tdata;
    logic [3:0]  tx_tuser;
`ifdef FIFO2PCIE_TX_STATS_EN
    logic [31:0] stat_pkt, stat_abort, stat_drop;
`endif

    fent_t fq[$];
    txb_t  eq[$];
    int    n_chk = 0;
    int    n_err = 0;
    int    n_pop = 0;
    int    pkt_id = 0;
    bit    prev_stall = 1'b0;
    bit    rd_s;
    txb_t  prev_b, cur_b, exp_b;

    fifo2pcie_tx dut (
        .pcie_clk     (pcie_clk),
        .pcie_rst_n   (pcie_rst_n),
        .fifo_empty   (fifo_empty),
        .fifo_tdata   (fifo_tdata),
        .fifo_tkeep   (fifo_tkeep),
        .fifo_tlast   (fifo_tlast),
        .fifo_tlp_len (fifo_tlp_len),
        .rd_en        (rd_en),
        .tx_buf_av    (tx_buf_av),
        .tx_tready    (tx_tready),
        .tx_tvalid    (tx_tvalid),
        .tx_tlast     (tx_tlast),
        .tx_tkeep     (tx_tkeep),
        .tx_tdata     (tx_tdata),
        .tx_tuser     (tx_tuser)
`ifdef FIFO2PCIE_TX_STATS_EN
        ,
        .stat_pkt     (stat_pkt),
        .stat_abort   (stat_abort),
        .stat_drop    (stat_drop)
`endif
    );

    always #5 pcie_clk = ~pcie_clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // FIFO head presentation, updated only by the monitor just after each rising edge
    task automatic refresh();
        if (fq.size() > 0) begin
            fifo_empty   = 1'b0;
            fifo_tdata   = fq[0].data;
            fifo_tkeep   = fq[0].keep;
            fifo_tlast   = fq[0].last;
            fifo_tlp_len = fq[0].len;
        end else begin
            fifo_empty   = 1'b1;
            fifo_tdata   = 64'h0;
            fifo_tkeep   = 8'h0;
            fifo_tlast   = 1'b0;
            fifo_tlp_len = 11'h0;
        end
    endtask

    task automatic step();
        @(posedge pcie_clk);
        #2;
    endtask

    task automatic push_beat(input logic [63:0] d, input logic [7:0] k, input logic l,
                             input logic [10:0] len);
        fent_t e;
        e.data = d; e.keep = k; e.last = l; e.len = len;
        fq.push_back(e);
    endtask

    // Push a whole FIFO packet and the TX beats it should produce
    task automatic send_pkt(input int len, input int nb);
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
        txb_t        e;
        int          expb;
        bit          drop;
        bit          done;
        expb = (len + 7) / 8;
        drop = (len < 12) || (nb == 1);
        done = 1'b0;
        pkt_id++;
        for (int i = 0; i < nb; i++) begin
            d = {16'(pkt_id), 16'(i), 32'($urandom)};
            l = (i == nb - 1);
            k = l ? 8'h0F : 8'hFF;
            push_beat(d, k, l, 11'(len));
            if (!drop && !done) begin
                e.data = d;
                e.keep = k;
                if (l && (i + 1 == expb)) begin
                    e.last = 1'b1; e.user = 4'h0;
                end else if (l) begin
                    e.last = 1'b1; e.user = 4'h8;
                end else if (i + 1 == expb) begin
                    e.last = 1'b1; e.user = 4'h8;
                end else begin
                    e.last = 1'b0; e.user = 4'h0;
                end
                eq.push_back(e);
                done = e.last;
            end
        end
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while ((fq.size() != 0 || eq.size() != 0 || tx_tvalid) && k < 2000) begin
            step();
            k++;
        end
        chk({tag, "_fifo_left"}, 128'(fq.size()), 128'(0));
        chk({tag, "_exp_left"}, 128'(eq.size()), 128'(0));
        step();
        step();
    endtask

    // Monitor: sample mid-cycle, score accepted beats, then pop the FIFO model after the edge
    always begin
        @(negedge pcie_clk);
        cur_b.data = tx_tdata;
        cur_b.keep = tx_tkeep;
        cur_b.last = tx_tlast;
        cur_b.user = tx_tuser;
        if (!pcie_rst_n) prev_stall = 1'b0;
        if (prev_stall) begin
            chk("stall_valid", 128'(tx_tvalid), 128'(1'b1));
            chk("stall_stable", 128'(cur_b), 128'(prev_b));
        end
        prev_stall = pcie_rst_n && tx_tvalid && !tx_tready;
        prev_b = cur_b;
        if (rd_en) chk("rd_en_underflow", 128'(fifo_empty), 128'(1'b0));
        if (tx_tvalid && tx_tready) begin
            if (eq.size() == 0) begin
                chk("unexpected_beat", 128'(eq.size()), 128'(1));
            end else begin
                exp_b = eq.pop_front();
                chk("tx_beat", 128'(cur_b), 128'(exp_b));
            end
        end
        rd_s = rd_en;
        @(posedge pcie_clk);
        #1;
        if (rd_s && fq.size() > 0) begin
            void'(fq.pop_front());
            n_pop++;
        end
        refresh();
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        txb_t e;
        pcie_rst_n = 1'b0;
        tx_tready  = 1'b1;
        tx_buf_av  = 6'd10;
        refresh();

        // Reset holds all outputs low even with a packet waiting
        send_pkt(16, 2);
        repeat (3) step();
        chk("rst_tvalid", 128'(tx_tvalid), 128'(1'b0));
        chk("rst_rd_en", 128'(rd_en), 128'(1'b0));
        chk("rst_tdata", 128'(tx_tdata), 128'(64'h0));
        chk("rst_tkeep", 128'(tx_tkeep), 128'(8'h0));
        chk("rst_tlast", 128'(tx_tlast), 128'(1'b0));
        chk("rst_tuser", 128'(tx_tuser), 128'(4'h0));
        chk("rst_fifo_held", 128'(fq.size()), 128'(2));

        // Basic 2-beat MWr, tready=1
        n_pop = 0;
        pcie_rst_n = 1'b1;
        wait_idle("basic");
        chk("basic_pops", 128'(n_pop), 128'(2));

        // Same TLP with tready toggling each cycle
        send_pkt(16, 2);
        for (int k = 0; k < 40 && (fq.size() != 0 || eq.size() != 0); k++) begin
            tx_tready = k[0];
            step();
        end
        tx_tready = 1'b1;
        wait_idle("toggle");

        // FIFO ends early (exp=3, 2 beats) followed by a clean TLP
        send_pkt(24, 2);
        send_pkt(16, 2);
        wait_idle("short");

        // FIFO packet longer than tlp_len: excess beats drained silently
        n_pop = 0;
        send_pkt(16, 4);
        wait_idle("long");
        chk("long_pops", 128'(n_pop), 128'(4));

        // Malformed entries dropped, then a good 4-beat TLP
        send_pkt(8, 1);
        send_pkt(16, 1);
        send_pkt(11, 2);
        send_pkt(32, 4);
        wait_idle("malformed");

        // Timeout: one beat, then FIFO stays empty
        push_beat(64'hA5A5_0000_1111_2222, 8'hFF, 1'b0, 11'd24);
        e.data = 64'hA5A5_0000_1111_2222; e.keep = 8'hFF; e.last = 1'b0; e.user = 4'h0;
        eq.push_back(e);
        e.data = 64'h0; e.keep = 8'hFF; e.last = 1'b1; e.user = 4'h8;
        eq.push_back(e);
        repeat (TO - 10) step();
        chk("timeout_not_early", 128'(eq.size()), 128'(1));
        repeat (30) step();
        chk("timeout_synth_sent", 128'(eq.size()), 128'(0));
        chk("timeout_tvalid_off", 128'(tx_tvalid), 128'(1'b0));
        push_beat(64'hDEAD_0001, 8'hFF, 1'b0, 11'd24);
        push_beat(64'hDEAD_0002, 8'h0F, 1'b1, 11'd24);
        wait_idle("late_drain");
        send_pkt(16, 2);
        wait_idle("after_timeout");

        // Credit gating: no start at tx_buf_av=1, start once it reaches 2
        tx_buf_av = 6'd1;
        tx_tready = 1'b0;
        send_pkt(16, 2);
        repeat (5) step();
        chk("credit_hold_tvalid", 128'(tx_tvalid), 128'(1'b0));
        chk("credit_hold_rd_en", 128'(rd_en), 128'(1'b0));
        chk("credit_hold_fifo", 128'(fq.size()), 128'(2));
        tx_buf_av = 6'd2;
        step();
        chk("credit_start_tvalid", 128'(tx_tvalid), 128'(1'b1));
        chk("credit_start_tdata", 128'(tx_tdata), 128'(fq[0].data));
        tx_buf_av = 6'd1;
        step();
        chk("credit_drop_tvalid", 128'(tx_tvalid), 128'(1'b1));
        tx_tready = 1'b1;
        wait_idle("credit");
        tx_buf_av = 6'd10;

        // Reset asserted in the middle of a stalled DATA beat
        send_pkt(32, 4);
        step();
        step();
        tx_tready = 1'b0;
        #1;
        chk("midrst_pre_tvalid", 128'(tx_tvalid), 128'(1'b1));
        pcie_rst_n = 1'b0;
        #1;
        chk("midrst_tvalid", 128'(tx_tvalid), 128'(1'b0));
        chk("midrst_rd_en", 128'(rd_en), 128'(1'b0));
        chk("midrst_tdata", 128'(tx_tdata), 128'(64'h0));
        chk("midrst_tlast", 128'(tx_tlast), 128'(1'b0));
        chk("midrst_tuser", 128'(tx_tuser), 128'(4'h0));
        fq.delete();
        eq.delete();
        step();
        step();
        pcie_rst_n = 1'b1;
        step();
        step();
        chk("postrst_tvalid", 128'(tx_tvalid), 128'(1'b0));
        tx_tready = 1'b1;
        send_pkt(16, 2);
        wait_idle("postrst");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
